// File: rtl/adjust_button_ctrl.sv
// Time-set button front-end: synchronises and debounces the up/down buttons and
// turns presses into single-cycle adjust strobes with hold-delay auto-repeat.
module adjust_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 1000,
    parameter int unsigned REPEAT_CYCLES   = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic adj_en,
    input  logic btn_up,
    input  logic btn_down,
    output logic up,
    output logic down,
    output logic held
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HLAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] RLAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat, StLock} state_t;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]         s1, s2;
    logic [1:0]         db, db_d;
    logic [1:0][DW-1:0] dcnt, dcnt_d;
    logic [1:0]         arm, arm_d;
    logic               live;

    state_t        state, state_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic          dir, dir_d;
    logic          up_d, down_d;
    logic [1:0]    pressed;
    logic          cur_next, other;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]   = db[i];
            dcnt_d[i] = dcnt[i];
            if (s2[i] == db[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt[i] == DLAST) begin
                db_d[i]   = s2[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt[i] + DW'(1);
            end
            // A press is only armed once the button has been seen fully released, so a
            // level held across reset or across a disabled period never counts as a press.
            arm_d[i] = db[i] ? 1'b0 : (arm[i] | (live & ~s1[i] & ~s2[i]));
        end
    end

    assign pressed  = db & arm;
    assign cur_next = db_d[dir];
    assign other    = db[~dir];

    always_comb begin
        state_d = state;
        tcnt_d  = tcnt;
        dir_d   = dir;
        up_d    = 1'b0;
        down_d  = 1'b0;
        if (!adj_en) begin
            state_d = StIdle;
            tcnt_d  = '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (db[0] && db[1]) begin
                        state_d = StLock;
                    end else if (pressed[0]) begin
                        up_d    = 1'b1;
                        dir_d   = 1'b0;
                        tcnt_d  = '0;
                        state_d = StHold;
                    end else if (pressed[1]) begin
                        down_d  = 1'b1;
                        dir_d   = 1'b1;
                        tcnt_d  = '0;
                        state_d = StHold;
                    end
                end
                StHold, StRepeat: begin
                    // Release is judged on the next debounced level so it beats a due repeat.
                    if (!cur_next) begin
                        state_d = StIdle;
                    end else if (other) begin
                        state_d = StLock;
                    end else if (tcnt == ((state == StHold) ? HLAST : RLAST)) begin
                        up_d    = ~dir;
                        down_d  = dir;
                        tcnt_d  = '0;
                        state_d = StRepeat;
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
                StLock: begin
                    if (!db[0] && !db[1]) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            dcnt  <= '0;
            arm   <= '0;
            live  <= 1'b0;
            state <= StIdle;
            tcnt  <= '0;
            dir   <= 1'b0;
            up    <= 1'b0;
            down  <= 1'b0;
            held  <= 1'b0;
        end else begin
            s1    <= {btn_down, btn_up};
            s2    <= s1;
            db    <= db_d;
            dcnt  <= dcnt_d;
            arm   <= arm_d;
            live  <= 1'b1;
            state <= state_d;
            tcnt  <= tcnt_d;
            dir   <= dir_d;
            up    <= up_d;
            down  <= down_d;
            held  <= (state == StHold) || (state == StRepeat);
        end
    end

endmodule
